calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Sequences the calculator datapath from the command/digit stream decoded off the UART.
- On each `update` strobe it applies the latched command to an accumulator: add/sub the digit, or shift left/right by one.
- It then runs an iterative double-dabble conversion of the accumulator to packed BCD for the display/echo path.
- A one-entry pending slot absorbs an `update` that arrives while busy; further updates are dropped and flagged.

Parameters:
- WIDTH, 8, accumulator width in bits.
- NDIG, 3, number of BCD digits output; must satisfy 10^NDIG > 2^WIDTH - 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- update  in  1  single-cycle strobe: execute `cmd` using `char`
- cmd  in  4  one-hot command {add, sub, lshift, rshift}, bit3 = add
- char  in  4  digit value 0-9; used by add/sub only
- clr_flags  in  1  clears the sticky `ovf` and `drop` flags
- acc  out  WIDTH  accumulator value
- bcd  out  4*NDIG  packed BCD of `acc`, least-significant digit in [3:0]
- valid  out  1  one-cycle pulse: `bcd` has just been updated
- busy  out  1  high when state != IDLE or the pending slot is full
- ovf  out  1  sticky carry/borrow/shift-out flag
- drop  out  1  sticky flag: an update was lost

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: acc=0, bcd=0, valid=0, busy=0, ovf=0, drop=0, pending empty, state IDLE.
- Reset mid-operation: aborts EXEC/CONV immediately; no `valid` pulse is produced.

State machine:
- IDLE:
  - If the pending slot is full, load its cmd/char into the op register, empty the slot, go to EXEC.
  - Otherwise, if `update` is high and `cmd` is a legal one-hot value, capture cmd/char into the op register, go to EXEC.
- EXEC (1 cycle): apply the op to `acc`, load the converter with `acc`'s new value, set iteration count = 0, go to CONV.
- CONV (WIDTH cycles): one double-dabble step per cycle — add 3 to each BCD nibble >= 5, then shift {bcd_work, bin_work} left by 1. After the WIDTH-th step, register `bcd`, pulse `valid`, go to IDLE.

Arithmetic (all modulo 2^WIDTH):
- add: acc + zero-extended `char`; sets `ovf` on carry out.
- sub: acc - `char`; sets `ovf` on borrow.
- lshift: acc << 1; sets `ovf` if the old MSB was 1.
- rshift: logical acc >> 1; never sets `ovf`.

Command validity:
- An illegal `cmd` (zero bits set, or more than one) is ignored.
- It is not queued and does not set `drop`.

Latency:
- `update` sampled at clock edge t in IDLE: `acc` changes after edge t+1.
- `valid` is high in the cycle after edge t+1+WIDTH.
- For WIDTH=8: update in cycle 0 gives valid in cycle 10.
- Back-to-back throughput is one op per WIDTH+2 cycles.

Pending slot:
- An `update` arriving while state != IDLE is stored if the slot is empty.
- If the slot is full, the update is discarded and `drop` is set.
- On the IDLE cycle that consumes the pending entry, a simultaneous new `update` refills the slot (no drop).

Flag priority:
- A flag set event in the same cycle as `clr_flags` wins: the flag ends up set.

Other outputs:
- `acc` and `bcd` hold their values between operations.

Decomposition:
- Package calc_pkg holds:
  - command bit indices: CMD_ADD=3, CMD_SUB=2, CMD_LSH=1, CMD_RSH=0
  - state encodings: IDLE, EXEC, CONV
  - the add-3 threshold constant
- Sub-module bin2bcd_iter (WIDTH, NDIG) is natural:
  - inputs: start, bin
  - outputs: bcd, done
  - owns its iteration counter and the double-dabble step
- calc_sequencer owns the FSM, pending slot, accumulator and flags.

Test Plan (WIDTH=8):
- After reset, update cmd=4'b1000 char=5 in cycle 0 -> acc=5 after cycle 1; valid=1 only in cycle 10; bcd=12'h005; ovf=0.
- acc=250, add char=9 -> acc=3, bcd=12'h003, ovf=1; then clr_flags -> ovf=0.
- acc=3, sub char=7 -> acc=252, bcd=12'h252, ovf=1.
- acc=8'h81: lshift -> acc=8'h02, ovf=1, bcd=12'h002; from 8'h81, rshift -> acc=8'h40, bcd=12'h064.
- Three add updates of char=1 in cycles 0, 2, 4 from acc=0 -> 2nd pending, 3rd dropped (drop=1); exactly two valid pulses; final acc=2, bcd=12'h002; busy low after.
- Assert rst during CONV (cycle 5 of an op) -> next cycle all outputs 0, no valid pulse; an update with cmd=4'b0011 is then ignored (busy stays 0).

Source files
------------

// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared constants and types for the calculator sequencer:
//   - bit positions of the one-hot command word
//   - FSM state encodings (exported on the debug state port)
//   - double-dabble add-3 threshold
//   - op_t: a captured command/digit pair (op register and pending slot)
//   - is_onehot4: command legality test
// ----------------------------------------------------------------------------
package calc_pkg;

    localparam int CMD_ADD = 3;
    localparam int CMD_SUB = 2;
    localparam int CMD_LSH = 1;
    localparam int CMD_RSH = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;

    // A BCD nibble at or above this value gets +3 before the shift.
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    typedef struct packed {
        logic [3:0] cmd;
        logic [3:0] chr;
    } op_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// ----------------------------------------------------------------------------
// bin2bcd_iter
// Iterative double-dabble converter: one add-3/shift step per clock,
// WIDTH steps per conversion.
//   clk, rst : clock, synchronous active-high reset
//   start    : load bin and begin a conversion (restarts any conversion)
//   bin      : binary value sampled with start
//   bcd      : result of the current step; final value when done is high
//   done     : high during the cycle whose step is the WIDTH-th one
// The caller registers bcd on the edge where done is high, so the result
// is available with no extra cycle after the last step.
// ----------------------------------------------------------------------------
module bin2bcd_iter
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic [4*NDIG-1:0]   bcd,
    output logic                done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                run_q, run_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [4*NDIG-1:0]   work_q, work_d;

    logic [4*NDIG-1:0]   adj;
    logic [4*NDIG-1:0]   step_bcd;
    logic [3:0]          nib;
    logic                last;

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        work_d = work_q;
        adj    = '0;
        nib    = '0;

        for (int i = 0; i < NDIG; i++) begin
            nib = work_q[4*i +: 4];
            adj[4*i +: 4] = (nib >= ADD3_THRESH) ? nib + 4'd3 : nib;
        end
        // Shift {bcd, bin} left by one: the binary MSB enters the BCD LSB.
        step_bcd = {adj[4*NDIG-2:0], bin_q[WIDTH-1]};
        last     = run_q && (cnt_q == CW'(WIDTH - 1));

        if (start) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            bin_d  = bin;
            work_d = '0;
        end else if (run_q) begin
            work_d = step_bcd;
            bin_d  = {bin_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            bin_q  <= '0;
            work_q <= '0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            work_q <= work_d;
        end
    end

    assign bcd  = step_bcd;
    assign done = last;

endmodule

// File: rtl/calc_sequencer.sv
// ----------------------------------------------------------------------------
// calc_sequencer
// Applies one-hot commands to an accumulator and converts the result to
// packed BCD, with a one-entry pending slot for updates that arrive busy.
//   clk, rst   : clock, synchronous active-high reset
//   update     : one-cycle strobe, execute cmd using char
//   cmd        : one-hot {add, sub, lshift, rshift}; illegal values ignored
//   char       : digit 0-9 for add/sub
//   clr_flags  : clear sticky ovf/drop (a same-cycle set wins)
//   acc        : accumulator
//   bcd        : packed BCD of acc, LS digit in [3:0]
//   valid      : one-cycle pulse when bcd has just been updated
//   busy       : FSM not idle or pending slot occupied
//   ovf        : sticky carry/borrow/shift-out
//   drop       : sticky, an update was lost
//   dbg_state  : current FSM state (ST_IDLE/ST_EXEC/ST_CONV)
//
// Handshake: update is a fire-and-forget strobe with no ready; the caller
// watches busy, and an update arriving with the pending slot full is lost
// and recorded in drop. valid is a single-cycle pulse with no backpressure.
// ----------------------------------------------------------------------------
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                update,
    input  logic [3:0]          cmd,
    input  logic [3:0]          char,
    input  logic                clr_flags,
    output logic [WIDTH-1:0]    acc,
    output logic [4*NDIG-1:0]   bcd,
    output logic                valid,
    output logic                busy,
    output logic                ovf,
    output logic                drop,
    output logic [1:0]          dbg_state
);

    logic [1:0]          state_q, state_d;
    op_t                 op_q, op_d;
    op_t                 pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic                drop_q, drop_d;

    logic                legal_upd;
    op_t                 new_op;
    logic                ovf_set;
    logic                drop_set;
    logic                conv_start;
    logic [4*NDIG-1:0]   conv_bcd;
    logic                conv_done;
    logic [WIDTH:0]      sum;
    logic [WIDTH:0]      diff;

    assign legal_upd = update && is_onehot4(cmd);
    assign new_op    = '{cmd: cmd, chr: char};

    // Bit WIDTH of sum is the carry; bit WIDTH of diff is the borrow.
    assign sum  = {1'b0, acc_q} + (WIDTH+1)'(op_q.chr);
    assign diff = {1'b0, acc_q} - (WIDTH+1)'(op_q.chr);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        acc_d       = acc_q;
        bcd_d       = bcd_q;
        valid_d     = 1'b0;
        ovf_set     = 1'b0;
        drop_set    = 1'b0;
        conv_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_full_q) begin
                    // Consuming the slot frees it this same cycle, so a
                    // simultaneous update refills it instead of dropping.
                    op_d        = pend_q;
                    pend_full_d = legal_upd;
                    if (legal_upd) begin
                        pend_d = new_op;
                    end
                    state_d = ST_EXEC;
                end else if (legal_upd) begin
                    op_d    = new_op;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q.cmd[CMD_ADD]) begin
                    acc_d   = sum[WIDTH-1:0];
                    ovf_set = sum[WIDTH];
                end else if (op_q.cmd[CMD_SUB]) begin
                    acc_d   = diff[WIDTH-1:0];
                    ovf_set = diff[WIDTH];
                end else if (op_q.cmd[CMD_LSH]) begin
                    acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                    ovf_set = acc_q[WIDTH-1];
                end else begin
                    acc_d   = {1'b0, acc_q[WIDTH-1:1]};
                end
                conv_start = 1'b1;
                state_d    = ST_CONV;
            end
            ST_CONV: begin
                if (conv_done) begin
                    bcd_d   = conv_bcd;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && legal_upd) begin
            if (!pend_full_q) begin
                pend_d      = new_op;
                pend_full_d = 1'b1;
            end else begin
                drop_set = 1'b1;
            end
        end

        ovf_d  = (ovf_q  && !clr_flags) || ovf_set;
        drop_d = (drop_q && !clr_flags) || drop_set;
    end

    // The converter loads the post-op accumulator value on the EXEC edge.
    bin2bcd_iter #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (acc_d),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            acc_q       <= '0;
            bcd_q       <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            acc_q       <= acc_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign acc       = acc_q;
    assign bcd       = bcd_q;
    assign valid     = valid_q;
    assign busy      = (state_q != ST_IDLE) || pend_full_q;
    assign ovf       = ovf_q;
    assign drop      = drop_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_calc_sequencer
// Bench for calc_sequencer (WIDTH=8, NDIG=3). The reference model works on
// a timeline of sample edges: an op started at edge e occupies the unit
// until edge e+WIDTH+2 and its result shows up after edge e+WIDTH+1.
// Expected results are queued when an op starts and compared by a monitor
// whenever valid is seen.
// ----------------------------------------------------------------------------
module tb_calc_sequencer;

    localparam int W = 8;
    localparam int N = 3;
    localparam logic [3:0] C_ADD = 4'b1000;
    localparam logic [3:0] C_SUB = 4'b0100;
    localparam logic [3:0] C_LSH = 4'b0010;
    localparam logic [3:0] C_RSH = 4'b0001;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           update = 1'b0;
    logic [3:0]     cmd = 4'd0;
    logic [3:0]     char_s = 4'd0;
    logic           clr_flags = 1'b0;
    logic [W-1:0]   acc;
    logic [4*N-1:0] bcd;
    logic           valid;
    logic           busy;
    logic           ovf;
    logic           drop;
    logic [1:0]     dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    calc_sequencer #(.WIDTH(W), .NDIG(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .update    (update),
        .cmd       (cmd),
        .char      (char_s),
        .clr_flags (clr_flags),
        .acc       (acc),
        .bcd       (bcd),
        .valid     (valid),
        .busy      (busy),
        .ovf       (ovf),
        .drop      (drop),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // entry = {valid_cycle[31:0], ovf, bcd[11:0], acc[7:0]}
    logic [52:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_acc = 0;
    int         m_ovf = 0;
    int         m_drop = 0;
    int         m_free = 0;
    int         m_pend = 0;
    logic [3:0] m_pcmd = 4'd0;
    int         m_pch = 0;
    int         model_en = 1;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic start_op(input int e, input logic [3:0] c, input int ch);
        int r;
        if (c == C_ADD) begin
            r = m_acc + ch;
            if (r > 255) m_ovf = 1;
            m_acc = r % 256;
        end else if (c == C_SUB) begin
            r = m_acc - ch;
            if (r < 0) m_ovf = 1;
            m_acc = (r + 256) % 256;
        end else if (c == C_LSH) begin
            if (m_acc >= 128) m_ovf = 1;
            m_acc = (m_acc * 2) % 256;
        end else begin
            m_acc = m_acc / 2;
        end
        m_free = e + W + 2;
        exp_q.push_back({32'(e + W + 1), 1'(m_ovf), to_bcd(m_acc), 8'(m_acc)});
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of inputs (sampled at the next edge e). A clear
    // request is honoured only while the model is fully idle with no update.
    task automatic step(input logic u, input logic [3:0] c, input logic [3:0] ch, input logic cl_req);
        int   e;
        logic legal;
        logic cl;
        @(posedge clk); #1;
        e     = cyc + 1;
        legal = u && ($countones(c) == 1);
        cl    = cl_req;
        if (model_en != 0)
            cl = cl_req && !u && (e >= m_free) && (m_pend == 0);
        update = u; cmd = c; char_s = ch; clr_flags = cl;
        if (model_en == 0) return;
        if (cl) begin
            m_ovf = 0;
            m_drop = 0;
        end
        if (e >= m_free && m_pend != 0) begin
            start_op(e, m_pcmd, m_pch);
            m_pend = 0;
            if (legal) begin
                m_pend = 1; m_pcmd = c; m_pch = int'(ch);
            end
        end else if (e >= m_free && legal) begin
            start_op(e, c, int'(ch));
        end else if (legal) begin
            if (m_pend == 0) begin
                m_pend = 1; m_pcmd = c; m_pch = int'(ch);
            end else begin
                m_drop = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; update = 1'b0; clr_flags = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0; m_ovf = 0; m_drop = 0; m_free = 0; m_pend = 0;
        exp_q.delete();
    endtask

    task automatic run_op(input logic [3:0] c, input int ch);
        step(1'b1, c, 4'(ch), 1'b0);
        idle(W + 2);
        chk("busy_after_op", 32'(busy), 0);
        chk("acc_after_op", 32'(acc), 32'(m_acc));
    endtask

    task automatic set_acc(input int t);
        do_reset();
        while (m_acc + 9 <= t) begin
            step(1'b1, C_ADD, 4'd9, 1'b0);
            idle(W + 1);
        end
        if (m_acc < t) begin
            step(1'b1, C_ADD, 4'(t - m_acc), 1'b0);
            idle(W + 1);
        end
        idle(1);
        chk("set_acc", 32'(acc), 32'(t));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [52:0] ent;
        if (valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(valid), 0);
            end else begin
                ent = exp_q.pop_front();
                chk("valid_cycle", 32'(cyc), ent[52:21]);
                chk("acc", 32'(acc), 32'(ent[7:0]));
                chk("bcd", 32'(bcd), 32'(ent[19:8]));
                chk("ovf", 32'(ovf), 32'(ent[20]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] c;
        logic [3:0] bad_cmds [4];
        int r;
        int k;
        bad_cmds[0] = 4'b0000; bad_cmds[1] = 4'b0011;
        bad_cmds[2] = 4'b1100; bad_cmds[3] = 4'b1111;

        do_reset();
        chk("rst_acc", 32'(acc), 0);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_drop", 32'(drop), 0);

        // add 5 from reset; latency checked by the monitor's valid_cycle
        step(1'b1, C_ADD, 4'd5, 1'b0);
        idle(1);
        chk("acc_latency_before", 32'(acc), 0);
        idle(1);
        chk("acc_latency_after", 32'(acc), 5);
        idle(W);
        chk("busy_idle", 32'(busy), 0);

        // carry: 250 + 9 -> 3 with ovf, then clear
        set_acc(250);
        run_op(C_ADD, 9);
        chk("ovf_carry", 32'(ovf), 1);
        step(1'b0, 4'd0, 4'd0, 1'b1);
        idle(1);
        chk("ovf_cleared", 32'(ovf), 0);

        // borrow: 3 - 7 -> 252
        run_op(C_SUB, 7);
        chk("ovf_borrow", 32'(ovf), 1);

        // shifts from 0x81
        set_acc(129);
        run_op(C_LSH, 0);
        chk("ovf_lsh", 32'(ovf), 1);
        set_acc(129);
        run_op(C_RSH, 0);
        chk("ovf_rsh", 32'(ovf), 0);

        // pending slot and drop
        do_reset();
        step(1'b1, C_ADD, 4'd1, 1'b0);
        idle(1);
        step(1'b1, C_ADD, 4'd1, 1'b0);
        idle(1);
        step(1'b1, C_ADD, 4'd1, 1'b0);
        idle(2 * W + 4);
        chk("drop_set", 32'(drop), 32'(m_drop));
        chk("drop_final_acc", 32'(acc), 2);
        chk("drop_final_bcd", 32'(bcd), 12'h002);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_queue_empty", 32'(exp_q.size()), 0);

        // reset in the middle of a conversion: no valid may follow
        do_reset();
        model_en = 0;
        step(1'b1, C_ADD, 4'd3, 1'b0);
        idle(5);
        do_reset();
        chk("midrst_acc", 32'(acc), 0);
        chk("midrst_bcd", 32'(bcd), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(valid), 0);
        idle(W + 4);
        step(1'b1, 4'b0011, 4'd5, 1'b0);
        idle(1);
        chk("illegal_busy", 32'(busy), 0);
        idle(W + 4);
        chk("illegal_acc", 32'(acc), 0);
        chk("illegal_drop", 32'(drop), 0);
        model_en = 1;

        // randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                k = $urandom_range(0, 5);
                if (k < 4) c = 4'(1 << k);
                else       c = bad_cmds[$urandom_range(0, 3)];
                step(1'b1, c, 4'($urandom_range(0, 9)), 1'b0);
            end else if (r == 3) begin
                step(1'b0, 4'd0, 4'd0, 1'b1);
            end else begin
                step(1'b0, 4'($urandom_range(0, 15)), 4'd0, 1'b0);
            end
        end
        idle(2 * W + 6);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        chk("final_acc", 32'(acc), 32'(m_acc));
        chk("final_bcd", 32'(bcd), 32'(to_bcd(m_acc)));
        chk("final_ovf", 32'(ovf), 32'(m_ovf));
        chk("final_drop", 32'(drop), 32'(m_drop));
        chk("final_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
